// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared types and encodings for the multi-cycle RV32I sequencer
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BEQ, S_JAL, S_TRAP
  } state_t;

  typedef enum logic [1:0] {ALU_OP_ADD, ALU_OP_SUB, ALU_OP_FUNCT} alu_op_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALU_OUT  = 2'b00;
  localparam logic [1:0] RES_MEM_DATA = 2'b01;
  localparam logic [1:0] RES_ALU      = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_INV = 3'b111;

  // Undecodable opcodes fall back to the I format; they trap anyway.
  function automatic logic [2:0] imm_for_op(input logic [6:0] op);
    logic [2:0] it;
    case (op)
      OP_SW:   it = IMM_S;
      OP_BEQ:  it = IMM_B;
      OP_JAL:  it = IMM_J;
      default: it = IMM_I;
    endcase
    return it;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps alu_op plus funct fields to the ALU control code
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] func3,
  input  logic       func7_b5,
  input  logic       op_b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_INV;
    case (alu_op)
      ALU_OP_ADD: alu_control = ALU_ADD;
      ALU_OP_SUB: alu_control = ALU_SUB;
      ALU_OP_FUNCT: begin
        case (func3)
          // func7[5] only selects sub for register-register ops, never for addi
          3'b000:  alu_control = (op_b5 & func7_b5) ? ALU_SUB : ALU_ADD;
          3'b111:  alu_control = ALU_AND;
          3'b110:  alu_control = ALU_OR;
          3'b010:  alu_control = ALU_SLT;
          default: alu_control = ALU_INV;
        endcase
      end
      default: alu_control = ALU_INV;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle RV32I control FSM over a shared memory port
module mc_controller
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter bit TIMEOUT_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op_code,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] imm_type,
  output logic [2:0] alu_control,
  output logic       instr_retired,
  output logic       illegal_instr,
  output logic       bus_error
);

  localparam int CW = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt;
  alu_op_t       alu_op;
  logic          mem_state, timeout, set_illegal, set_bus_err;
  logic          func7_unused;

  assign func7_unused = ^{func7[6], func7[4:0]};
  assign mem_state    = state inside {S_FETCH, S_MEM_RD, S_MEM_WR};
  // Only consulted when mem_ready is low, so a ready on the last cycle still wins.
  assign timeout      = TIMEOUT_EN && mem_state && !mem_ready && (wait_cnt == WAIT_LAST);

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .func3       (func3),
    .func7_b5    (func7[5]),
    .op_b5       (op_code[5]),
    .alu_control (alu_control)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_RESET;
      wait_cnt      <= '0;
      illegal_instr <= 1'b0;
      bus_error     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        wait_cnt <= '0;
      else if (mem_state && !mem_ready && wait_cnt != '1)
        wait_cnt <= wait_cnt + CW'(1);
      if (set_illegal) illegal_instr <= 1'b1;
      if (set_bus_err) bus_error <= 1'b1;
    end
  end

  always_comb begin
    state_nxt     = state;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_RS2;
    result_src    = RES_ALU_OUT;
    imm_type      = IMM_I;
    alu_op        = ALU_OP_ADD;
    instr_retired = 1'b0;
    set_illegal   = 1'b0;
    set_bus_err   = 1'b0;
    case (state)
      S_RESET: state_nxt = S_FETCH;
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          state_nxt = S_DECODE;
        end else if (timeout) begin
          set_bus_err = 1'b1;
          state_nxt   = S_TRAP;
        end
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_IMM;
        imm_type  = imm_for_op(op_code);
        case (op_code)
          OP_LW, OP_SW: state_nxt = S_MEM_ADR;
          OP_R:         state_nxt = S_EXEC_R;
          OP_I:         state_nxt = S_EXEC_I;
          OP_BEQ:       state_nxt = S_BEQ;
          OP_JAL:       state_nxt = S_JAL;
          default: begin
            set_illegal = 1'b1;
            state_nxt   = S_TRAP;
          end
        endcase
      end
      S_MEM_ADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        imm_type  = (op_code == OP_SW) ? IMM_S : IMM_I;
        state_nxt = (op_code == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_nxt = S_MEM_WB;
        else if (timeout) begin
          set_bus_err = 1'b1;
          state_nxt   = S_TRAP;
        end
      end
      S_MEM_WB: begin
        result_src    = RES_MEM_DATA;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        state_nxt     = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) begin
          instr_retired = 1'b1;
          state_nxt     = S_FETCH;
        end else if (timeout) begin
          set_bus_err = 1'b1;
          state_nxt   = S_TRAP;
        end
      end
      S_EXEC_R: begin
        alu_src_a = SRC_A_RS1;
        alu_op    = ALU_OP_FUNCT;
        state_nxt = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_OP_FUNCT;
        state_nxt = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        state_nxt     = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a     = SRC_A_RS1;
        alu_op        = ALU_OP_SUB;
        pc_write      = zero;
        instr_retired = 1'b1;
        state_nxt     = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_FOUR;
        pc_write  = 1'b1;
        state_nxt = S_ALU_WB;
      end
      S_TRAP:  state_nxt = S_TRAP;
      default: state_nxt = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - scoreboard bench for the multi-cycle control FSM
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       rst_n, zero, mem_ready;
  logic [6:0] op_code, func7;
  logic [2:0] func3;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] imm_type, alu_control;
  logic       instr_retired, illegal_instr, bus_error;

  mc_controller #(.MEM_TIMEOUT(4), .TIMEOUT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .op_code(op_code), .func3(func3), .func7(func7),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .imm_type(imm_type), .alu_control(alu_control), .instr_retired(instr_retired),
    .illegal_instr(illegal_instr), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [20:0] v;
    string       name;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  logic exp_ill = 1'b0;
  logic exp_bus = 1'b0;

  // {mem_req,mem_write,adr_src,ir_write,pc_write,reg_write, src_a, src_b, result_src, imm_type, alu_control, retired}
  localparam logic [18:0] E_ZERO    = 19'd0;
  localparam logic [18:0] E_FETCH_W = {6'b100000, 2'b00, 2'b10, 2'b10, 3'b000, 3'b000, 1'b0};
  localparam logic [18:0] E_FETCH_G = {6'b100110, 2'b00, 2'b10, 2'b10, 3'b000, 3'b000, 1'b0};
  localparam logic [18:0] E_DEC_I   = {6'b000000, 2'b01, 2'b01, 2'b00, 3'b000, 3'b000, 1'b0};
  localparam logic [18:0] E_DEC_S   = {6'b000000, 2'b01, 2'b01, 2'b00, 3'b001, 3'b000, 1'b0};
  localparam logic [18:0] E_DEC_B   = {6'b000000, 2'b01, 2'b01, 2'b00, 3'b010, 3'b000, 1'b0};
  localparam logic [18:0] E_DEC_J   = {6'b000000, 2'b01, 2'b01, 2'b00, 3'b011, 3'b000, 1'b0};
  localparam logic [18:0] E_ALU_WB  = {6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b1};
  localparam logic [18:0] E_ADR_L   = {6'b000000, 2'b10, 2'b01, 2'b00, 3'b000, 3'b000, 1'b0};
  localparam logic [18:0] E_ADR_S   = {6'b000000, 2'b10, 2'b01, 2'b00, 3'b001, 3'b000, 1'b0};
  localparam logic [18:0] E_RD      = {6'b101000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0};
  localparam logic [18:0] E_MEM_WB  = {6'b000001, 2'b00, 2'b00, 2'b01, 3'b000, 3'b000, 1'b1};
  localparam logic [18:0] E_WR_W    = {6'b111000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0};
  localparam logic [18:0] E_WR_G    = {6'b111000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b1};
  localparam logic [18:0] E_BEQ_T   = {6'b000010, 2'b10, 2'b00, 2'b00, 3'b000, 3'b001, 1'b1};
  localparam logic [18:0] E_BEQ_N   = {6'b000000, 2'b10, 2'b00, 2'b00, 3'b000, 3'b001, 1'b1};
  localparam logic [18:0] E_JAL     = {6'b000010, 2'b01, 2'b10, 2'b00, 3'b000, 3'b000, 1'b0};

  function automatic logic [18:0] ex_r(input logic [2:0] ac);
    return {6'b000000, 2'b10, 2'b00, 2'b00, 3'b000, ac, 1'b0};
  endfunction

  function automatic logic [18:0] ex_i(input logic [2:0] ac);
    return {6'b000000, 2'b10, 2'b01, 2'b00, 3'b000, ac, 1'b0};
  endfunction

  wire [20:0] act = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                     alu_src_a, alu_src_b, result_src, imm_type, alu_control,
                     instr_retired, illegal_instr, bus_error};

  task automatic step(input logic mr, input logic z, input string nm, input logic [18:0] e);
    @(posedge clk);
    #1;
    mem_ready = mr;
    zero      = z;
    q.push_back('{v: {e, exp_ill, exp_bus}, name: nm});
  endtask

  // Asserts reset mid-cycle so the negedge check sees the asynchronous clear.
  task automatic rst_pulse(input string nm);
    @(posedge clk);
    #2;
    rst_n   = 1'b0;
    exp_ill = 1'b0;
    exp_bus = 1'b0;
    q.push_back('{v: 21'd0, name: nm});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.push_back('{v: 21'd0, name: {nm, "_rel"}});
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    op_code = op;
    func3   = f3;
    func7   = f7;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (act !== e.v) begin
        bad++;
        $display("FAIL %s: got=%b want=%b", e.name, act, e.v);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [2:0] ac;
    string      nm;
  } alu_vec_t;

  alu_vec_t alu_vecs[6];

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0;
    set_instr(7'd0, 3'd0, 7'd0);
    alu_vecs[0] = '{7'b0110011, 3'b000, 7'b0100000, 3'b001, "r_sub"};
    alu_vecs[1] = '{7'b0110011, 3'b111, 7'b0000000, 3'b010, "r_and"};
    alu_vecs[2] = '{7'b0110011, 3'b010, 7'b0000000, 3'b101, "r_slt"};
    alu_vecs[3] = '{7'b0110011, 3'b001, 7'b0000000, 3'b111, "r_inv"};
    alu_vecs[4] = '{7'b0010011, 3'b000, 7'b0100000, 3'b000, "i_add_f7"};
    alu_vecs[5] = '{7'b0010011, 3'b110, 7'b0000000, 3'b011, "i_or"};

    rst_pulse("reset");

    for (int i = 0; i < 6; i++) begin
      set_instr(alu_vecs[i].op, alu_vecs[i].f3, alu_vecs[i].f7);
      step(1'b1, 1'b0, {alu_vecs[i].nm, "_fetch"}, E_FETCH_G);
      step(1'b1, 1'b0, {alu_vecs[i].nm, "_dec"}, E_DEC_I);
      step(1'b1, 1'b0, {alu_vecs[i].nm, "_exec"},
           (alu_vecs[i].op == 7'b0110011) ? ex_r(alu_vecs[i].ac) : ex_i(alu_vecs[i].ac));
      step(1'b1, 1'b0, {alu_vecs[i].nm, "_wb"}, E_ALU_WB);
    end

    set_instr(7'b0000011, 3'b010, 7'd0);
    step(1'b1, 1'b0, "lw_fetch", E_FETCH_G);
    step(1'b1, 1'b0, "lw_dec", E_DEC_I);
    step(1'b1, 1'b0, "lw_adr", E_ADR_L);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "lw_rd_wait", E_RD);
    step(1'b1, 1'b0, "lw_rd_go", E_RD);
    step(1'b0, 1'b0, "lw_wb", E_MEM_WB);

    set_instr(7'b1100011, 3'b000, 7'd0);
    step(1'b0, 1'b0, "beq_fetch_wait0", E_FETCH_W);
    step(1'b0, 1'b0, "beq_fetch_wait1", E_FETCH_W);
    step(1'b1, 1'b0, "beq_fetch", E_FETCH_G);
    step(1'b1, 1'b0, "beq_dec", E_DEC_B);
    step(1'b1, 1'b1, "beq_taken", E_BEQ_T);
    step(1'b1, 1'b0, "beq2_fetch", E_FETCH_G);
    step(1'b1, 1'b0, "beq2_dec", E_DEC_B);
    step(1'b1, 1'b0, "beq_not_taken", E_BEQ_N);

    set_instr(7'b1101111, 3'b000, 7'd0);
    step(1'b1, 1'b0, "jal_fetch", E_FETCH_G);
    step(1'b1, 1'b0, "jal_dec", E_DEC_J);
    step(1'b1, 1'b0, "jal_exec", E_JAL);
    step(1'b1, 1'b0, "jal_wb", E_ALU_WB);

    set_instr(7'b0100011, 3'b010, 7'd0);
    step(1'b1, 1'b0, "sw_fetch", E_FETCH_G);
    step(1'b1, 1'b0, "sw_dec", E_DEC_S);
    step(1'b1, 1'b0, "sw_adr", E_ADR_S);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "sw_wait", E_WR_W);
    step(1'b1, 1'b0, "sw_ready_last", E_WR_G);

    step(1'b1, 1'b0, "sw2_fetch", E_FETCH_G);
    step(1'b1, 1'b0, "sw2_dec", E_DEC_S);
    step(1'b1, 1'b0, "sw2_adr", E_ADR_S);
    step(1'b0, 1'b0, "sw2_wait", E_WR_W);
    rst_pulse("wr_async_rst");

    step(1'b1, 1'b0, "sw3_fetch", E_FETCH_G);
    step(1'b1, 1'b0, "sw3_dec", E_DEC_S);
    step(1'b1, 1'b0, "sw3_adr", E_ADR_S);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, "sw3_wait", E_WR_W);
    exp_bus = 1'b1;
    step(1'b0, 1'b0, "sw3_bus_trap", E_ZERO);
    step(1'b1, 1'b0, "sw3_trap_hold", E_ZERO);
    rst_pulse("trap_rst");

    set_instr(7'b1110011, 3'b000, 7'd0);
    step(1'b1, 1'b0, "ill_fetch", E_FETCH_G);
    step(1'b1, 1'b0, "ill_dec", E_DEC_I);
    exp_ill = 1'b1;
    for (int i = 0; i < 4; i++) step(i[0], 1'b0, "ill_trap", E_ZERO);

    @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got=%0d pending want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
